pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 32: width of the internal counter and of the period/high_time outputs.
REQ-002 Parameter TIMEOUT, default 1000000: clk_in cycles without a rising edge before a timeout is declared; SHALL be < 2^CNT_W and >= 4.
REQ-003 clk_in  input  1  sole clock; every register SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 sig_in  input  1  asynchronous slow square/PWM wave to measure, e.g. a divided clock.
REQ-006 period  output  CNT_W  clk_in cycles between the last two detected rising edges.
REQ-007 high_time  output  CNT_W  clk_in cycles sig_in was high within that period.
REQ-008 meas_valid  output  1  one-cycle strobe; period/high_time updated this cycle.
REQ-009 timeout  output  1  level; no rising edge seen for TIMEOUT cycles.

Function
REQ-010 sig_in SHALL pass through two synchronizer flops s1, s2, then a history flop s3.
REQ-011 Edge decode: rise = s2 & ~s3; fall = ~s2 & s3.
REQ-012 FSM SHALL have two states, IDLE and MEASURE; reset state IDLE.
REQ-013 IDLE + rise: go to MEASURE, cnt <= 0, fall_seen <= 0, no meas_valid.
REQ-014 IDLE without rise: cnt held at 0; outputs hold.
REQ-015 MEASURE, each cycle without rise: cnt <= cnt + 1.
REQ-016 MEASURE + fall: hi_lat <= cnt + 1 and fall_seen <= 1; only the first fall per period is latched.
REQ-017 MEASURE + rise with fall_seen=1: drive meas_valid=1 for the next cycle. In the same update, period <= cnt + 1, high_time <= hi_lat, timeout <= 0, cnt <= 0, fall_seen <= 0.
REQ-018 MEASURE + rise with fall_seen=0 (cannot occur legally; defensive): restart only (cnt <= 0), no meas_valid.
REQ-019 All outputs SHALL be registered; meas_valid SHALL be high exactly one cycle per completed period.
REQ-020 Latency: meas_valid SHALL be high in the cycle after the 3rd rising clk_in edge following a sig_in rise that meets setup.
REQ-021 MEASURE, no rise, cnt == TIMEOUT-1: timeout <= 1, period <= 0, high_time <= 0, cnt <= 0, state <= IDLE.
REQ-022 Timeout and rise in the same cycle: rise SHALL win (REQ-017); timeout not set.
REQ-023 cnt SHALL never wrap; it is bounded by TIMEOUT-1 (REQ-021).
REQ-024 timeout stays 1 until the next meas_valid; re-entry from IDLE alone does not clear it.
REQ-025 Minimum measurable period: 2 cycles (high_time 1). Narrower pulses may be lost in synchronization; no error flag.
REQ-026 sig_in already high at reset release SHALL register as a first rise (s3 resets to 0): enter MEASURE, no meas_valid.

Reset
REQ-027 rst=1 at a clk_in edge SHALL clear s1, s2, s3, cnt, hi_lat, fall_seen, period, high_time, meas_valid and timeout to 0, and set state to IDLE.
REQ-028 Reset mid-measurement SHALL discard the partial period; the first rise after release is treated per REQ-013.
REQ-029 rst SHALL take priority over every other event in the same cycle.

Verification
REQ-030 Drive sig_in from a divider toggling every 50 clk_in cycles -> from the 2nd rise on: meas_valid once per 100 cycles, period=100, high_time=50.
REQ-031 sig_in high 30 / low 70 cycles, repeating -> period=100, high_time=30 each period; consecutive meas_valid pulses exactly 100 cycles apart.
REQ-032 TIMEOUT=1000, sig_in stuck low after one rise -> timeout=1 at cycle 1000 after the rise; period=0, high_time=0. Resume 20/20 toggling -> 1st rise no strobe, 2nd rise meas_valid with period=40, high_time=20, timeout=0.
REQ-033 Assert rst for 1 cycle at mid-period during 50/50 toggling -> all outputs 0 next cycle; first meas_valid only after two further rises; values correct (100/50).
REQ-034 Single sig_in rise with setup met -> s3 high 3 edges later; no meas_valid (first edge). Next rise -> meas_valid exactly 3 edges after that rise.
REQ-035 Arrange the rise exactly at cnt == TIMEOUT-1 -> meas_valid=1, period=TIMEOUT, timeout stays 0.

Source files
------------

// File: rtl/pwm_capture_if.sv
// pwm_capture_if -- measurement bus of the PWM capture block.
//   sig_in     : slow square/PWM wave to be measured (asynchronous to clk_in)
//   period     : clk_in cycles between the last two rising edges
//   high_time  : clk_in cycles sig_in was high within that period
//   meas_valid : one-cycle strobe, period/high_time updated this cycle
//   timeout    : level, no rising edge seen for TIMEOUT cycles
// master = capture block (produces results), slave = consumer (drives sig_in).
interface pwm_capture_if #(
  parameter int CNT_W = 32
);
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             timeout;

  modport master (
    input  sig_in,
    output period, high_time, meas_valid, timeout
  );

  modport slave (
    output sig_in,
    input  period, high_time, meas_valid, timeout
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture -- measures period and high time of a slow asynchronous wave.
//   clk_in : sole clock
//   rst    : synchronous, active-high reset
//   bus    : pwm_capture_if.master (sig_in in; period, high_time,
//            meas_valid, timeout out -- all outputs registered)
// sig_in is synchronized through two flops plus a history flop; edges are
// decoded from the last two stages. A two-state FSM counts cycles between
// rising edges, latches the first fall of each period and declares a
// timeout when no rising edge arrives within TIMEOUT cycles.
module pwm_capture #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic          clk_in,
  input  logic          rst,
  pwm_capture_if.master bus
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] hi_lat_q;
  logic             fall_seen_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_time_q;
  logic             meas_valid_q;
  logic             timeout_q;

  logic             rise_d;
  logic             fall_d;
  logic [CNT_W-1:0] cnt_inc_d;

  assign rise_d    = s2_q & ~s3_q;
  assign fall_d    = ~s2_q & s3_q;
  assign cnt_inc_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q      <= IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      cnt_q        <= '0;
      hi_lat_q     <= '0;
      fall_seen_q  <= 1'b0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      // synchronizer and edge history
      s1_q         <= bus.sig_in;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      meas_valid_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (rise_d) begin
            state_q     <= MEASURE;
            fall_seen_q <= 1'b0;
          end
        end

        MEASURE: begin
          if (rise_d) begin
            // A rise closes the period; it wins over a simultaneous timeout.
            // Without a latched fall the rise is spurious: just restart.
            if (fall_seen_q) begin
              meas_valid_q <= 1'b1;
              period_q     <= cnt_inc_d;
              high_time_q  <= hi_lat_q;
              timeout_q    <= 1'b0;
            end
            cnt_q       <= '0;
            fall_seen_q <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            // Counter bound reached: report timeout and wait for a new rise.
            // timeout_q remains set until the next completed measurement.
            timeout_q   <= 1'b1;
            period_q    <= '0;
            high_time_q <= '0;
            cnt_q       <= '0;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_inc_d;
            if (fall_d && !fall_seen_q) begin
              hi_lat_q    <= cnt_inc_d;
              fall_seen_q <= 1'b1;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_time_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture -- randomized/directed stimulus for pwm_capture, checked
// every cycle against an event-level reference model: transitions of the
// driven wave become rise/fall events seen two edges later by the block,
// and period/high time are differences between event times.
module tb_pwm_capture;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1000;

  logic clk_in;
  logic rst;

  pwm_capture_if #(.CNT_W(CNT_W)) bus ();

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus.master)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int t;
    bit rise;
  } evt_t;

  evt_t q_evt[$];
  bit   prev_smp;
  bit   armed;       // a rise has been seen, measurement in progress
  bit   have_fall;
  int   last_rise;
  int   fall_t;
  int   exp_period, exp_high;
  bit   exp_mv, exp_to;

  task automatic model_step(input bit r, input bit s);
    evt_t ev;
    bit   is_rise, is_fall;
    if (r) begin
      q_evt.delete();
      prev_smp = 0; armed = 0; have_fall = 0;
      exp_period = 0; exp_high = 0; exp_mv = 0; exp_to = 0;
      return;
    end
    exp_mv  = 0;
    is_rise = 0;
    is_fall = 0;
    if (q_evt.size() > 0 && q_evt[0].t == cyc) begin
      ev = q_evt.pop_front();
      is_rise = ev.rise;
      is_fall = !ev.rise;
    end
    if (is_rise) begin
      if (armed && have_fall) begin
        exp_mv     = 1;
        exp_period = cyc - last_rise;
        exp_high   = fall_t - last_rise;
        exp_to     = 0;
      end
      armed     = 1;
      have_fall = 0;
      last_rise = cyc;
    end else if (armed && (cyc - last_rise == TIMEOUT)) begin
      exp_to     = 1;
      exp_period = 0;
      exp_high   = 0;
      armed      = 0;
    end else if (is_fall && armed && !have_fall) begin
      have_fall = 1;
      fall_t    = cyc;
    end
    if (s != prev_smp) begin
      ev.t    = cyc + 2;
      ev.rise = s;
      q_evt.push_back(ev);
    end
    prev_smp = s;
  endtask

  // One clock: model consumes the values sampled at this edge, then outputs
  // are compared 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_in);
    cyc++;
    model_step(rst, bus.sig_in);
    #1;
    check("meas_valid", {31'd0, bus.meas_valid}, {31'd0, exp_mv});
    check("timeout",    {31'd0, bus.timeout},    {31'd0, exp_to});
    check("period",     32'(bus.period),         32'(exp_period));
    check("high_time",  32'(bus.high_time),      32'(exp_high));
  endtask

  task automatic level(input bit v, input int n);
    bus.sig_in = v;
    repeat (n) tick();
  endtask

  task automatic pulse(input int hi, input int lo);
    level(1'b1, hi);
    level(1'b0, lo);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  int mv_seen;

  initial begin
    bus.sig_in = 1'b0;
    rst        = 1'b0;
    #1;
    do_reset(2);

    // 50/50 divider: 100/50 from the second rise on
    repeat (5) pulse(50, 50);

    // 30/70 duty
    repeat (4) pulse(30, 70);

    // random widths including 1-cycle high/low phases
    repeat (30) pulse($urandom_range(1, 60), $urandom_range(1, 60));

    // stuck low after a rise -> timeout; then 20/20 recovers
    pulse(20, 1100);
    repeat (4) pulse(20, 20);

    // reset mid-period during 50/50
    repeat (2) pulse(50, 50);
    level(1'b1, 25);
    do_reset(1);
    level(1'b1, 25);
    level(1'b0, 50);
    repeat (3) pulse(50, 50);

    // period exactly TIMEOUT: rise wins; one cycle longer: timeout
    repeat (2) pulse(10, TIMEOUT - 10);
    pulse(10, TIMEOUT - 9);
    repeat (3) pulse(15, 15);

    // sig_in already high at reset release counts as a first rise
    bus.sig_in = 1'b1;
    do_reset(2);
    level(1'b1, 40);
    level(1'b0, 40);
    mv_seen = 0;
    repeat (3) begin
      pulse(40, 40);
      if (bus.period == CNT_W'(80)) mv_seen++;
    end
    check("period_80_after_reset_high", 32'(mv_seen), 32'd3);

    // a few more random periods, then quiet
    repeat (10) pulse($urandom_range(1, 80), $urandom_range(1, 80));
    level(1'b0, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
